tlp_tx_arbiter: RTL and testbench
=================================

Name: tlp_tx_arbiter

Overview:
- Merges NUM_CH independent FPGA->Host TLP streams into the single tx pipe of the PCIe core.
- Streams use the same 64-bit SOP/EOP/valid/ready convention as the core's tx pipe.
- Arbitration is packet-atomic: once a channel wins, all its beats pass through unbroken until EOP, then the next grant is decided.
- Lets several application engines share one PCIe link without cooperating with each other.

Parameters:
- NUM_CH, 4, number of upstream channels (1..16).
- DATA_WIDTH, 64, beat width in bits.
- PRIORITY_MODE, 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
- CH_BITS, max(1,$clog2(NUM_CH)), width of the channel index (derived; do not override).

Ports:
- pcieClk_in  in  1  sole clock; all logic is on its rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- chData_in  in  NUM_CH*DATA_WIDTH  per-channel beat data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- chSOP_in  in  NUM_CH  per-channel start of packet.
- chEOP_in  in  NUM_CH  per-channel end of packet.
- chValid_in  in  NUM_CH  per-channel beat valid.
- chReady_out  out  NUM_CH  per-channel beat accepted.
- txData_out  out  DATA_WIDTH  merged beat to the core.
- txSOP_out  out  1  merged start of packet.
- txEOP_out  out  1  merged end of packet.
- txValid_out  out  1  merged beat valid.
- txReady_in  in  1  core accepts the beat.
- grantCh_out  out  CH_BITS  index of the currently locked channel.
- busy_out  out  1  high while a packet is locked.
- protoErr_out  out  1  sticky protocol-error flag, cleared only by reset.

Behaviour:
- Beat transfer: a beat transfers on a channel when its valid and ready are both high at a rising edge. Upstream sources must hold data, SOP, EOP and valid until accepted.
- Reset (async assert, sync release): state=IDLE, grantCh_out=0, busy_out=0, protoErr_out=0, last-grant pointer=NUM_CH-1. txValid_out, chReady_out, txSOP_out and txEOP_out are all 0; txData_out is don't-care.
- FSM states: IDLE, LOCKED.
- IDLE, request set: req[i] = chValid_in[i] & chSOP_in[i].
- IDLE, winner selection:
  - Round-robin: the first requesting index scanning upward from pointer+1, wrapping modulo NUM_CH.
  - Fixed priority: the lowest requesting index.
- IDLE, with a winner: register grantCh=winner and pointer=winner, go to LOCKED. No beat is forwarded in this cycle (1-cycle arbitration bubble).
- IDLE, no winner: stay in IDLE.
- IDLE, output drive: txValid_out=0 and chReady_out=0.
- IDLE, protocol error: a channel with valid=1 and SOP=0 in IDLE sets protoErr_out. That channel is never granted until it presents SOP, which means it stalls.
- LOCKED, forwarding (purely combinational, 0-cycle latency):
  - txData/SOP/EOP/Valid_out = channel grantCh's inputs.
  - chReady_out[grantCh] = txReady_in; all other chReady_out bits = 0.
- LOCKED, exit: a transfer with EOP=1 returns the FSM to IDLE on that edge. The next arbitration happens in the following cycle, so every packet boundary costs exactly one bubble cycle.
- LOCKED, protocol error: a transfer with SOP=1 that is not the first beat of the locked packet sets protoErr_out. The beat is still forwarded.
- Single-beat packets (SOP=EOP=1) are legal: the FSM goes IDLE -> LOCKED -> IDLE.
- busy_out = (state==LOCKED). grantCh_out holds its value while in IDLE.
- Back-pressure: txReady_in low stalls the locked channel only. Other channels' requests are ignored until EOP.
- Reset asserted mid-packet: the FSM aborts immediately to the reset state. The truncated packet is the upstream's responsibility.
- NUM_CH=1: the FSM still applies (bubble per packet); grantCh_out is constant 0.

Test Plan:
- Round-robin fairness: NUM_CH=4; channels 0 and 2 each continuously offer 3-beat packets (data 0xA0.., 0xC0..). Required: output order ch0, ch2, ch0, ch2; each packet is contiguous; exactly 1 idle cycle between packets; grantCh_out=0,2,0,2.
- Fixed priority: PRIORITY_MODE=1; channels 1 and 3 both request at the same edge. Required: ch1 is granted first. ch3 is granted after ch1's EOP only if ch1 presents no new SOP in that IDLE cycle; otherwise ch1 keeps winning.
- Back-pressure: hold txReady_in=0 for 5 cycles mid-packet on ch2. Required: chReady_out=0 for all channels, txData_out stable, no beat lost or duplicated after release.
- Single-beat packets: ch3 sends 4 consecutive SOP=EOP=1 beats, values 0x1..0x4. Required: 4 output beats, each followed by one bubble; busy_out toggles 1,0 per packet.
- Protocol error: ch1 asserts valid without SOP in IDLE -> protoErr_out=1 on the next cycle and ch1 is not granted. In a separate run, ch0 sends SOP on its second beat -> the beat is forwarded and protoErr_out=1. Asserting reset_in clears the flag.
- Reset mid-packet: assert reset_in during beat 2 of 4. Required: txValid_out=0, busy_out=0, chReady_out=0 immediately, without waiting for a clock edge; after release, the first grant goes to the lowest requesting index at or above 0 (pointer=NUM_CH-1).

Source files
------------

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic arbiter merging NUM_CH upstream TLP streams onto the single PCIe tx pipe.
// Round-robin or fixed-priority grant, with a one-cycle bubble at every packet boundary.
//
// state  | meaning
// IDLE   | no packet locked; choose a winner among channels presenting SOP
// LOCKED | forward beats of grantCh combinationally until its EOP transfers
module tlp_tx_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int PRIORITY_MODE = 0,
  parameter int CH_BITS       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         pcieClk_in,
  input  logic                         reset_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chData_in,
  input  logic [NUM_CH-1:0]            chSOP_in,
  input  logic [NUM_CH-1:0]            chEOP_in,
  input  logic [NUM_CH-1:0]            chValid_in,
  output logic [NUM_CH-1:0]            chReady_out,
  output logic [DATA_WIDTH-1:0]        txData_out,
  output logic                         txSOP_out,
  output logic                         txEOP_out,
  output logic                         txValid_out,
  input  logic                         txReady_in,
  output logic [CH_BITS-1:0]           grantCh_out,
  output logic                         busy_out,
  output logic                         protoErr_out
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state, stateNext;
  logic [CH_BITS-1:0] grantCh, grantNext;
  logic [CH_BITS-1:0] lastGrant, lastGrantNext;
  logic protoErr, protoErrNext;
  logic midPkt, midPktNext;

  logic [NUM_CH-1:0] req, strayBeat;
  logic found, foundHi, foundLo;
  logic [CH_BITS-1:0] winner, winHi, winLo;
  logic [DATA_WIDTH-1:0] selData;
  logic selSop, selEop, selValid, busy, xfer;

  assign req       = chValid_in & chSOP_in;
  assign strayBeat = chValid_in & ~chSOP_in;

  // Round-robin is "lowest requester above lastGrant, else lowest requester overall".
  always_comb begin
    foundHi = 1'b0;
    winHi   = '0;
    foundLo = 1'b0;
    winLo   = '0;
    found   = 1'b0;
    winner  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        foundLo = 1'b1;
        winLo   = CH_BITS'(i);
      end
      if (req[i] && (CH_BITS'(i) > lastGrant)) begin
        foundHi = 1'b1;
        winHi   = CH_BITS'(i);
      end
    end
    if ((PRIORITY_MODE == 1) || !foundHi) begin
      found  = foundLo;
      winner = winLo;
    end else begin
      found  = 1'b1;
      winner = winHi;
    end
  end

  always_comb begin
    selData  = '0;
    selSop   = 1'b0;
    selEop   = 1'b0;
    selValid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grantCh == CH_BITS'(i)) begin
        selData  = chData_in[i*DATA_WIDTH +: DATA_WIDTH];
        selSop   = chSOP_in[i];
        selEop   = chEOP_in[i];
        selValid = chValid_in[i];
      end
    end
  end

  assign busy = (state == LOCKED);
  assign xfer = busy & selValid & txReady_in;

  always_comb begin
    chReady_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chReady_out[i] = busy && (grantCh == CH_BITS'(i)) && txReady_in;
    end
  end

  assign txData_out   = selData;
  assign txSOP_out    = busy & selSop;
  assign txEOP_out    = busy & selEop;
  assign txValid_out  = busy & selValid;
  assign grantCh_out  = grantCh;
  assign busy_out     = busy;
  assign protoErr_out = protoErr;

  always_comb begin
    stateNext     = state;
    grantNext     = grantCh;
    lastGrantNext = lastGrant;
    protoErrNext  = protoErr;
    midPktNext    = midPkt;
    case (state)
      IDLE: begin
        if (|strayBeat) protoErrNext = 1'b1;
        if (found) begin
          stateNext     = LOCKED;
          grantNext     = winner;
          lastGrantNext = winner;
          midPktNext    = 1'b0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          midPktNext = 1'b1;
          if (selSop && midPkt) protoErrNext = 1'b1;
          if (selEop) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= IDLE;
      grantCh   <= '0;
      lastGrant <= CH_BITS'(NUM_CH - 1);
      protoErr  <= 1'b0;
      midPkt    <= 1'b0;
    end else begin
      state     <= stateNext;
      grantCh   <= grantNext;
      lastGrant <= lastGrantNext;
      protoErr  <= protoErrNext;
      midPkt    <= midPktNext;
    end
  end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Bench for tlp_tx_arbiter: round-robin and fixed-priority instances, queue-fed sources,
// a cycle model checked every cycle, and literal beat-order expectations per scenario.
module tb_tlp_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [N*DW-1:0] chData[2];
  logic [N-1:0] chSOP[2], chEOP[2], chValid[2], chReady[2];
  logic [DW-1:0] txData[2];
  logic txSOP[2], txEOP[2], txValid[2], txReady[2];
  logic [1:0] grantCh[2];
  logic busy[2], protoErr[2];

  tlp_tx_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .PRIORITY_MODE(0)) dutRr (
    .pcieClk_in(clk), .reset_in(rst), .chData_in(chData[0]), .chSOP_in(chSOP[0]),
    .chEOP_in(chEOP[0]), .chValid_in(chValid[0]), .chReady_out(chReady[0]),
    .txData_out(txData[0]), .txSOP_out(txSOP[0]), .txEOP_out(txEOP[0]),
    .txValid_out(txValid[0]), .txReady_in(txReady[0]), .grantCh_out(grantCh[0]),
    .busy_out(busy[0]), .protoErr_out(protoErr[0]));

  tlp_tx_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .PRIORITY_MODE(1)) dutFp (
    .pcieClk_in(clk), .reset_in(rst), .chData_in(chData[1]), .chSOP_in(chSOP[1]),
    .chEOP_in(chEOP[1]), .chValid_in(chValid[1]), .chReady_out(chReady[1]),
    .txData_out(txData[1]), .txSOP_out(txSOP[1]), .txEOP_out(txEOP[1]),
    .txValid_out(txValid[1]), .txReady_in(txReady[1]), .grantCh_out(grantCh[1]),
    .busy_out(busy[1]), .protoErr_out(protoErr[1]));

  typedef struct packed {logic [63:0] d; logic s; logic e;} beat_t;
  beat_t mem[2][N][32];
  int head[2][N];
  int tail[2][N];
  bit pop[2][N];
  bit flushReq;

  bit mLocked[2], mErr[2], mMid[2];
  int mGrant[2], mPtr[2];

  logic [63:0] logD[2][64];
  int logCh[2][64], logCyc[2][64], logN[2];
  int cyc;
  int nChk, nFail;

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL inst%0d %s: got %0h expected %0h at t=%0t", d, nm, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int c, input logic [63:0] data, input logic s, input logic e);
    mem[d][c][tail[d][c]] = '{d: data, s: s, e: e};
    tail[d][c]++;
  endtask

  task automatic waitLog(input int d, input int n);
    int k;
    k = 0;
    while (logN[d] < n && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk(d, "beatsArrived", logN[d] >= n, 1);
  endtask

  task automatic logChk(input int d, input int idx, input logic [63:0] expD, input int expCh);
    chk(d, $sformatf("beat%0d.data", idx), logD[d][idx], expD);
    chk(d, $sformatf("beat%0d.ch", idx), logCh[d][idx], expCh);
  endtask

  task automatic gapChk(input int d, input int idx, input int expGap);
    chk(d, $sformatf("gap%0d", idx), logCyc[d][idx] - logCyc[d][idx-1], expGap);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sources hold their head beat until the model says it was accepted.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        if (flushReq) head[d][c] = tail[d][c];
        else if (pop[d][c] && !rst) head[d][c]++;
        if (head[d][c] < tail[d][c]) begin
          chData[d][c*DW +: DW] = mem[d][c][head[d][c]].d;
          chSOP[d][c]   = mem[d][c][head[d][c]].s;
          chEOP[d][c]   = mem[d][c][head[d][c]].e;
          chValid[d][c] = 1'b1;
        end else begin
          chData[d][c*DW +: DW] = '0;
          chSOP[d][c]   = 1'b0;
          chEOP[d][c]   = 1'b0;
          chValid[d][c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic eV, eS, eE;
    logic [63:0] eD;
    logic [N-1:0] eR, rq;
    bit fnd;
    int w, g, c;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mLocked[d] = 0; mGrant[d] = 0; mPtr[d] = N - 1; mErr[d] = 0; mMid[d] = 0;
      end
      g = mGrant[d];
      eV = 0; eS = 0; eE = 0; eD = '0; eR = '0;
      if (mLocked[d]) begin
        eV = chValid[d][g];
        eS = chSOP[d][g];
        eE = chEOP[d][g];
        eD = chData[d][g*DW +: DW];
        eR = txReady[d] ? (4'b0001 << g) : 4'b0000;
      end
      chk(d, "txValid", txValid[d], eV);
      chk(d, "chReady", chReady[d], eR);
      chk(d, "busy", busy[d], mLocked[d]);
      chk(d, "grantCh", grantCh[d], mGrant[d]);
      chk(d, "protoErr", protoErr[d], mErr[d]);
      chk(d, "txSOP", txSOP[d], eS);
      chk(d, "txEOP", txEOP[d], eE);
      if (eV) chk(d, "txData", txData[d], eD);
      for (int k = 0; k < N; k++) pop[d][k] = 0;
      if (txValid[d] === 1'b1 && txReady[d] && !rst && logN[d] < 64) begin
        logD[d][logN[d]] = txData[d];
        logCh[d][logN[d]] = int'(grantCh[d]);
        logCyc[d][logN[d]] = cyc;
        logN[d]++;
      end
      if (!rst) begin
        if (!mLocked[d]) begin
          rq = chValid[d] & chSOP[d];
          if ((chValid[d] & ~chSOP[d]) != 0) mErr[d] = 1;
          fnd = 0; w = 0;
          for (int k = 1; k <= N; k++) begin
            c = (d == 0) ? (mPtr[d] + k) % N : k - 1;
            if (!fnd && rq[c]) begin fnd = 1; w = c; end
          end
          if (fnd) begin mLocked[d] = 1; mGrant[d] = w; mPtr[d] = w; mMid[d] = 0; end
        end else if (eV && txReady[d]) begin
          pop[d][g] = 1;
          if (eS && mMid[d]) mErr[d] = 1;
          mMid[d] = 1;
          if (eE) mLocked[d] = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] expD1 [12];
    int expC1 [12];
    logic [63:0] expD2 [7];
    int expC2 [7];
    int base;
    expD1 = '{64'hA0, 64'hA1, 64'hA2, 64'hC0, 64'hC1, 64'hC2,
              64'hA3, 64'hA4, 64'hA5, 64'hC3, 64'hC4, 64'hC5};
    expC1 = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2};
    expD2 = '{64'h20, 64'h21, 64'h22, 64'h23, 64'hB0, 64'hB1, 64'hD0};
    expC2 = '{2, 2, 2, 2, 0, 0, 1};

    rst = 1'b1;
    flushReq = 1'b0;
    txReady[0] = 1'b1;
    txReady[1] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst.busy", busy[d], 0);
      chk(d, "rst.grant", grantCh[d], 0);
      chk(d, "rst.protoErr", protoErr[d], 0);
      chk(d, "rst.txValid", txValid[d], 0);
      chk(d, "rst.chReady", chReady[d], 0);
    end
    rst = 1'b0;

    // Round-robin fairness between ch0 and ch2, 3-beat packets
    base = logN[0];
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) begin
        push(0, 0, 64'hA0 + 64'(p*3 + b), b == 0, b == 2);
        push(0, 2, 64'hC0 + 64'(p*3 + b), b == 0, b == 2);
      end
    end
    waitLog(0, base + 12);
    for (int i = 0; i < 12; i++) logChk(0, base + i, expD1[i], expC1[i]);
    for (int i = 1; i < 12; i++) gapChk(0, base + i, (i % 3 == 0) ? 2 : 1);

    // Back-pressure on ch2 for 5 cycles while ch0/ch1 queue up
    base = logN[0];
    push(0, 2, 64'h20, 1, 0);
    push(0, 2, 64'h21, 0, 0);
    push(0, 2, 64'h22, 0, 0);
    push(0, 2, 64'h23, 0, 1);
    waitLog(0, base + 1);
    @(posedge clk); #3;
    txReady[0] = 1'b0;
    push(0, 0, 64'hB0, 1, 0);
    push(0, 0, 64'hB1, 0, 1);
    push(0, 1, 64'hD0, 1, 1);
    repeat (5) begin
      @(negedge clk); #1;
      chk(0, "stall.chReady", chReady[0], 0);
      chk(0, "stall.txData", txData[0], 64'h21);
    end
    @(posedge clk); #3;
    txReady[0] = 1'b1;
    waitLog(0, base + 7);
    for (int i = 0; i < 7; i++) logChk(0, base + i, expD2[i], expC2[i]);
    gapChk(0, base + 1, 6);

    // Single-beat packets on ch3
    base = logN[0];
    for (int i = 1; i <= 4; i++) push(0, 3, 64'(i), 1, 1);
    waitLog(0, base + 4);
    for (int i = 0; i < 4; i++) logChk(0, base + i, 64'(i + 1), 3);
    for (int i = 1; i < 4; i++) gapChk(0, base + i, 2);

    // Valid without SOP while idle
    repeat (2) @(negedge clk);
    #1;
    chk(0, "preErr", protoErr[0], 0);
    push(0, 1, 64'h55, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk(0, "idleErr.flag", protoErr[0], 1);
    chk(0, "idleErr.busy", busy[0], 0);
    @(posedge clk); #3;
    rst = 1'b1; flushReq = 1'b1;
    @(posedge clk); #3;
    flushReq = 1'b0; rst = 1'b0;
    chk(0, "idleErr.cleared", protoErr[0], 0);

    // SOP on the second beat of a locked packet
    base = logN[0];
    push(0, 0, 64'h70, 1, 0);
    push(0, 0, 64'h71, 1, 0);
    push(0, 0, 64'h72, 0, 1);
    waitLog(0, base + 3);
    for (int i = 0; i < 3; i++) logChk(0, base + i, 64'h70 + 64'(i), 0);
    chk(0, "midSop.flag", protoErr[0], 1);
    @(posedge clk); #3;
    rst = 1'b1; flushReq = 1'b1;
    @(posedge clk); #3;
    flushReq = 1'b0; rst = 1'b0;
    chk(0, "midSop.cleared", protoErr[0], 0);

    // Reset during beat 2 of 4; pointer must restart at NUM_CH-1
    base = logN[0];
    push(0, 1, 64'h80, 1, 0);
    push(0, 1, 64'h81, 0, 0);
    push(0, 1, 64'h82, 0, 0);
    push(0, 1, 64'h83, 0, 1);
    push(0, 3, 64'h90, 1, 0);
    push(0, 3, 64'h91, 0, 1);
    waitLog(0, base + 1);
    @(posedge clk); #3;
    chk(0, "preRst.busy", busy[0], 1);
    rst = 1'b1;
    #1;
    chk(0, "asyncRst.txValid", txValid[0], 0);
    chk(0, "asyncRst.busy", busy[0], 0);
    chk(0, "asyncRst.chReady", chReady[0], 0);
    flushReq = 1'b1;
    @(posedge clk); #3;
    flushReq = 1'b0;
    push(0, 3, 64'hA8, 1, 1);
    push(0, 1, 64'hB8, 1, 1);
    rst = 1'b0;
    waitLog(0, base + 3);
    logChk(0, base, 64'h80, 1);
    logChk(0, base + 1, 64'hB8, 1);
    logChk(0, base + 2, 64'hA8, 3);

    // Fixed priority: ch1 keeps winning while it presents SOP, then ch3
    base = logN[1];
    push(1, 1, 64'h11, 1, 0);
    push(1, 1, 64'h12, 0, 1);
    push(1, 1, 64'h13, 1, 1);
    push(1, 3, 64'h31, 1, 1);
    waitLog(1, base + 4);
    logChk(1, base, 64'h11, 1);
    logChk(1, base + 1, 64'h12, 1);
    logChk(1, base + 2, 64'h13, 1);
    logChk(1, base + 3, 64'h31, 3);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
